// File: rtl/move_pkg.sv
// Shared types and defaults for the move-instruction sequencer.
package move_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int TIMEOUT_DEF    = 15;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SRC_DEV  = 3'd1,
    SRC_ADDR = 3'd2,
    TGT_DEV  = 3'd3,
    TGT_ADDR = 3'd4,
    RD       = 3'd5,
    WR       = 3'd6
  } state_e;

endpackage

// File: rtl/move_sched_if.sv
// Instruction stream + device bus bundle for move_sched.
// master: the sequencer side; slave: instruction memory / device bus side.
interface move_sched_if #(
  parameter int DATA_WIDTH = 16
) ();

  logic [DATA_WIDTH-1:0] ir;
  logic                  ir_valid;
  logic                  ir_ready;
  logic [DATA_WIDTH-1:0] dev_sel;
  logic [DATA_WIDTH-1:0] dev_addr;
  logic                  dev_rd;
  logic                  dev_wr;
  logic [DATA_WIDTH-1:0] dev_wdata;
  logic [DATA_WIDTH-1:0] dev_rdata;
  logic                  dev_ack;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    input  ir, ir_valid, dev_rdata, dev_ack,
    output ir_ready, dev_sel, dev_addr, dev_rd, dev_wr, dev_wdata, busy, done, err
  );

  modport slave (
    output ir, ir_valid, dev_rdata, dev_ack,
    input  ir_ready, dev_sel, dev_addr, dev_rd, dev_wr, dev_wdata, busy, done, err
  );

endinterface

// File: rtl/move_timeout.sv
// Bus-phase timeout counter: counts request cycles, flags the last allowed one.
module move_timeout #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Clear wins over counting; saturate so a stuck phase cannot wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CW'(TIMEOUT))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // High during the TIMEOUT-th request cycle of the current phase.
  assign expired = en && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/move_sched.sv
// Move-instruction sequencer: fetches src dev/addr and tgt dev/addr words,
// then performs one device read and one device write of the captured data.
// Optional feature macro: MOVE_TIMEOUT_EN (aborts a bus phase after TIMEOUT
// request cycles without ack and pulses err).
module move_sched
  import move_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input logic          clk,
  input logic          rst,
  move_sched_if.master bus
);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] src_dev_q, src_dev_d;
  logic [DATA_WIDTH-1:0] src_addr_q, src_addr_d;
  logic [DATA_WIDTH-1:0] tgt_dev_q, tgt_dev_d;
  logic [DATA_WIDTH-1:0] tgt_addr_q, tgt_addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  expired;

  logic                  ir_ready;
  logic                  busy;
  logic                  dev_rd;
  logic                  dev_wr;
  logic [DATA_WIDTH-1:0] dev_sel;
  logic [DATA_WIDTH-1:0] dev_addr;
  logic [DATA_WIDTH-1:0] dev_wdata;

`ifdef MOVE_TIMEOUT_EN
  logic in_phase;
  assign in_phase = (state_q == RD) || (state_q == WR);

  // Counter restarts whenever a phase is not active or has just ended.
  move_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (!in_phase || bus.dev_ack || expired),
    .en      (in_phase),
    .expired (expired)
  );
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign expired        = 1'b0;
`endif

  // State, operand and pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      src_dev_q  <= '0;
      src_addr_q <= '0;
      tgt_dev_q  <= '0;
      tgt_addr_q <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_dev_q  <= src_dev_d;
      src_addr_q <= src_addr_d;
      tgt_dev_q  <= tgt_dev_d;
      tgt_addr_q <= tgt_addr_d;
      data_q     <= data_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Next state: fetch words on accept, then wait for ack in RD and WR
  // (ack beats timeout when both land in the same cycle).
  always_comb begin
    state_d    = state_q;
    src_dev_d  = src_dev_q;
    src_addr_d = src_addr_q;
    tgt_dev_d  = tgt_dev_q;
    tgt_addr_d = tgt_addr_q;
    data_d     = data_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      IDLE: state_d = SRC_DEV;
      SRC_DEV: if (bus.ir_valid) begin
        src_dev_d = bus.ir;
        state_d   = SRC_ADDR;
      end
      SRC_ADDR: if (bus.ir_valid) begin
        src_addr_d = bus.ir;
        state_d    = TGT_DEV;
      end
      TGT_DEV: if (bus.ir_valid) begin
        tgt_dev_d = bus.ir;
        state_d   = TGT_ADDR;
      end
      TGT_ADDR: if (bus.ir_valid) begin
        tgt_addr_d = bus.ir;
        state_d    = RD;
      end
      RD: begin
        if (bus.dev_ack) begin
          data_d  = bus.dev_rdata;
          state_d = WR;
        end else if (expired) begin
          err_d   = 1'b1;
          state_d = SRC_DEV;
        end
      end
      WR: begin
        if (bus.dev_ack) begin
          done_d  = 1'b1;
          state_d = SRC_DEV;
        end else if (expired) begin
          err_d   = 1'b1;
          state_d = SRC_DEV;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode purely from registered state.
  always_comb begin
    ir_ready  = 1'b0;
    busy      = 1'b0;
    dev_rd    = 1'b0;
    dev_wr    = 1'b0;
    dev_sel   = '0;
    dev_addr  = '0;
    dev_wdata = '0;
    case (state_q)
      SRC_DEV: ir_ready = 1'b1;
      SRC_ADDR, TGT_DEV, TGT_ADDR: begin
        ir_ready = 1'b1;
        busy     = 1'b1;
      end
      RD: begin
        busy     = 1'b1;
        dev_rd   = 1'b1;
        dev_sel  = src_dev_q;
        dev_addr = src_addr_q;
      end
      WR: begin
        busy      = 1'b1;
        dev_wr    = 1'b1;
        dev_sel   = tgt_dev_q;
        dev_addr  = tgt_addr_q;
        dev_wdata = data_q;
      end
      default: ;
    endcase
  end

  assign bus.ir_ready  = ir_ready;
  assign bus.busy      = busy;
  assign bus.dev_rd    = dev_rd;
  assign bus.dev_wr    = dev_wr;
  assign bus.dev_sel   = dev_sel;
  assign bus.dev_addr  = dev_addr;
  assign bus.dev_wdata = dev_wdata;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: doc/move_sched.md
# move_sched

Sequencer for the move-instruction datapath. It accepts the four-word move instruction stream (source device, source address, target device, target address) and drives the shared device bus: one read from the source, then one write of the captured data to the target. It sits between instruction memory and the device bus, replacing free-running word counting with valid/ready and ack handshakes.

## Interface
- DATA_WIDTH, 16, width of instruction words, device IDs, addresses and data
- TIMEOUT, 15, max request cycles per bus phase (used only with MOVE_TIMEOUT_EN)

- clk  input  1  clock, rising edge
- rst  input  1  reset; asynchronous, active-high
- ir  input  DATA_WIDTH  instruction word
- ir_valid  input  1  ir holds a valid word
- ir_ready  output  1  block accepts ir this cycle
- dev_sel  output  DATA_WIDTH  device ID for current bus phase
- dev_addr  output  DATA_WIDTH  address for current bus phase
- dev_rd  output  1  read request
- dev_wr  output  1  write request
- dev_wdata  output  DATA_WIDTH  write data
- dev_rdata  input  DATA_WIDTH  read data, valid with dev_ack in a read phase
- dev_ack  input  1  bus phase complete
- busy  output  1  move in progress
- done  output  1  one-cycle pulse: move completed
- err  output  1  one-cycle pulse: move aborted on timeout

## Operation
- States: IDLE, SRC_DEV, SRC_ADDR, TGT_DEV, TGT_ADDR, RD, WR.
- IDLE → SRC_DEV unconditionally. This gives one dead cycle after reset.
- A word is accepted when ir_valid && ir_ready. ir_ready = 1 only in the four fetch states.
- Each fetch state latches ir into its register (src_dev, src_addr, tgt_dev, tgt_addr) on accept, then advances. With no accept, the state holds.
- RD: dev_rd=1, dev_sel=src_dev, dev_addr=src_addr. On dev_ack, capture dev_rdata into data_reg and go to WR.
- WR: dev_wr=1, dev_sel=tgt_dev, dev_addr=tgt_addr, dev_wdata=data_reg. On dev_ack, go to SRC_DEV and pulse done.
- Outside RD/WR: dev_sel, dev_addr and dev_wdata are 0; dev_rd and dev_wr are 0.
- dev_ack outside RD/WR is ignored.
- busy = 1 in SRC_ADDR, TGT_DEV, TGT_ADDR, RD and WR.
- src_dev == tgt_dev is legal; no special handling.
- Reset values: state IDLE; all registers 0; every output 0.

## Timing
- State and data registers are flops. All outputs decode from registered state, so there is no combinational path from ir_valid or dev_ack to any output.
- dev_ack is sampled on the rising edge. With zero-wait ack, each bus phase lasts 1 cycle.
- Minimum move: 4 accept cycles + RD + WR = 6 cycles. done is high in the cycle after the WR ack edge, concurrent with SRC_DEV, where ir_ready is already 1. Back-to-back moves therefore have no bubble.
- Request signals and their dev_sel/dev_addr stay stable until ack.
- Reset mid-operation: all outputs drop asynchronously; the outstanding request is abandoned and done is not pulsed. After reset release, the block spends one IDLE cycle, then enters SRC_DEV.

## Configuration
- MOVE_TIMEOUT_EN defined:
  - A counter clears on entry to RD or WR and counts request cycles.
  - If dev_ack has not arrived after TIMEOUT request cycles, the block aborts to SRC_DEV and pulses err for 1 cycle; done is not pulsed and WR is skipped.
  - If ack arrives in the TIMEOUT-th cycle, the ack wins.
- Not defined: phases wait indefinitely, err is tied 0, and TIMEOUT is unused.

## Structure
- Shared package move_pkg holds the state enumeration (IDLE…WR) and the DATA_WIDTH default constant.
- Sub-module move_timeout holds the timeout counter (clear, count enable, expired flag). It is instantiated only under MOVE_TIMEOUT_EN.

## Test plan
- Zero-wait move: ir 0x0003, 0x0010, 0x0005, 0x0020 back-to-back; dev_ack=1, dev_rdata=0xBEEF → RD 1 cycle with sel 3 / addr 0x10; WR 1 cycle with sel 5 / addr 0x20 / wdata 0xBEEF; done 6 cycles after first accept.
- ir_valid low for 3 cycles between words 2 and 3 → ir_ready stays 1, state holds, no dev_rd/dev_wr, move completes correctly.
- dev_ack delayed 3 cycles in RD → dev_rd high 4 cycles with sel/addr stable; data captured only on the ack cycle.
- rst asserted in WR → dev_wr and busy drop immediately, no done; after release, 1 IDLE cycle, then ir_ready=1.
- MOVE_TIMEOUT_EN, TIMEOUT=4, no ack in RD → dev_rd high exactly 4 cycles, err pulse next cycle, no dev_wr, next move accepted.
- Two moves back-to-back → first word of move 2 accepted in the cycle done is high.
